// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: IMEM address/data, redirect request and the decode handshake.
// master = fetch controller, slave = the surrounding core/IMEM.
interface imem_fetch_ctrl_if #(
    parameter int unsigned PC_W = 8
) ();
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads the combinational IMEM every
// cycle and queues {pc, instr} pairs in a 2-entry buffer towards decode. Handles
// start-up, branch/jump redirects (with flush) and end-of-program detection.
module imem_fetch_ctrl #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    imem_fetch_ctrl_if.master bus,
    output logic             done,
    output logic             fetch_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One extra bit so the range compare works even when DEPTH == 2**PC_W.
    localparam logic [PC_W:0]   DEPTH_X    = (PC_W + 1)'(DEPTH);
    localparam logic [PC_W-1:0] LAST_PC    = PC_W'(DEPTH - 1);
    localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic [1:0]      count_q, count_d;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    logic [PC_W-1:0] ent_pc_q [2];
    logic [PC_W-1:0] ent_pc_d [2];
    logic [31:0]     ent_instr_q [2];
    logic [31:0]     ent_instr_d [2];

    logic redirect;
    logic redirect_ok;
    logic head_valid;
    logic pop;
    logic push;

    // Handshake and redirect decode.
    always_comb begin
        redirect    = bus.redirect_valid;
        redirect_ok = ({1'b0, bus.redirect_pc} < DEPTH_X);
        head_valid  = (count_q != 2'd0);
        pop         = head_valid && bus.out_ready;
        push        = (state_q == ST_RUN) && !redirect && ((count_q != 2'd2) || pop);
    end

    // Control FSM, fetch PC and sticky error flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        if (redirect) begin
            pc_d = bus.redirect_pc;
            if (redirect_ok) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_DONE;
                err_d   = 1'b1;
            end
        end else if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_RUN;
            end
        end else if (push) begin
            pc_d = pc_q + PC_W'(1);
            if (pc_q == LAST_PC) begin
                state_d = ST_DONE;
            end
        end
    end

    // Buffer next state: push/pop bookkeeping, full flush on redirect.
    always_comb begin
        ent_pc_d    = ent_pc_q;
        ent_instr_d = ent_instr_q;
        count_d     = count_q;
        if (redirect) begin
            // A same-cycle pop is already accepted by decode; everything else is dropped.
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    ent_pc_d[0]    = ent_pc_q[1];
                    ent_instr_d[0] = ent_instr_q[1];
                    count_d        = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent_pc_d[0]    = pc_q;
                        ent_instr_d[0] = bus.imem_data;
                    end else begin
                        ent_pc_d[1]    = pc_q;
                        ent_instr_d[1] = bus.imem_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        ent_pc_d[0]    = ent_pc_q[1];
                        ent_instr_d[0] = ent_instr_q[1];
                        ent_pc_d[1]    = pc_q;
                        ent_instr_d[1] = bus.imem_data;
                    end else begin
                        ent_pc_d[0]    = pc_q;
                        ent_instr_d[0] = bus.imem_data;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC_W;
            err_q          <= 1'b0;
            count_q        <= 2'd0;
            ent_pc_q[0]    <= '0;
            ent_pc_q[1]    <= '0;
            ent_instr_q[0] <= '0;
            ent_instr_q[1] <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            err_q          <= err_d;
            count_q        <= count_d;
            ent_pc_q[0]    <= ent_pc_d[0];
            ent_pc_q[1]    <= ent_pc_d[1];
            ent_instr_q[0] <= ent_instr_d[0];
            ent_instr_q[1] <= ent_instr_d[1];
        end
    end

    // Outputs come straight from registers (count decode only).
    always_comb begin
        bus.imem_addr = pc_q;
        bus.out_valid = head_valid;
        bus.out_instr = ent_instr_q[0];
        bus.out_pc    = ent_pc_q[0];
        done          = (state_q == ST_DONE);
        fetch_err     = err_q;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller that sequences the combinational, word-indexed instruction memory for the MIPS core. It owns the fetch PC, drives the IMEM address every cycle, and captures each returned word together with its PC into a 2-entry buffer. It presents that buffer to decode over a valid/ready handshake, and it handles branch/jump redirects, start-up and end-of-program detection.

## Interface
- `PC_W`, 8: width of the fetch PC and the IMEM word index.
- `DEPTH`, 64: number of IMEM words. Valid indices are 0..DEPTH-1.
- `RESET_PC`, 0: word index loaded into the fetch PC at reset.
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins fetching from the current fetch PC.
- `imem_addr`  out  PC_W  word index to IMEM. Equals the fetch PC register.
- `imem_data`  in  32  instruction word returned combinationally by IMEM for `imem_addr`.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  PC_W  target word index for the redirect.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  instruction at the buffer head.
- `out_pc`  out  PC_W  word index of `out_instr`.
- `done`  out  1  high while in state DONE.
- `fetch_err`  out  1  sticky flag: a redirect targeted an index >= DEPTH.

## Operation
- States:
  - IDLE (reset state): no fetching.
  - RUN: fetching.
  - DONE: fetch PC has passed DEPTH-1 or a redirect went out of range. No fetching.
- Transitions, in priority order:
  1. `redirect_valid` (from any state):
     - `redirect_pc` < DEPTH: go to RUN, fetch PC <= `redirect_pc`.
     - Otherwise: go to DONE, fetch PC <= `redirect_pc`, `fetch_err` <= 1.
  2. In IDLE, `start`: go to RUN.
  3. In RUN, a push whose PC equals DEPTH-1: go to DONE after that push.
  - `start` is ignored in RUN and DONE.
- Buffer: 2-entry FIFO of {pc, instr}.
  - Pop occurs when `out_valid` && `out_ready`.
  - Push occurs in RUN, with no redirect, when count < 2 or a pop happens this cycle.
  - A push stores {fetch PC, `imem_data`} and increments the fetch PC by 1 (PC_W-bit wrap; reaching DEPTH is caught by DONE first).
- Redirect flush:
  - A pop in the same cycle completes normally; decode has accepted that word.
  - All other buffer entries are discarded.
  - No push occurs in the redirect cycle.
  - Count becomes 0 next cycle.
- Simultaneous push and pop with count=2: both occur and count stays 2.
- Outputs are driven from registers only. `imem_addr` is the fetch PC register; `out_*` come from the buffer head.
- Reset, including mid-operation: state IDLE, fetch PC = RESET_PC, count = 0, `out_valid`=0, `out_instr`=0, `out_pc`=0, `done`=0, `fetch_err`=0, `imem_addr`=RESET_PC.

## Timing
- `start` sampled at edge k gives RUN in cycle k+1. The first push happens at edge k+1 and `out_valid`=1 in cycle k+2.
- Steady state with `out_ready` held 1: one instruction per cycle, consecutive `out_pc` values, no bubbles.
- `out_ready`=0 for 2+ cycles: the buffer fills to 2, the fetch PC holds, and `imem_addr` is stable. Throughput resumes the cycle after `out_ready` returns to 1.
- Redirect asserted in cycle t: `out_valid`=0 in cycle t+1, and the target instruction is at the head with `out_valid`=1 in cycle t+2.
- End of program: after the push of PC DEPTH-1, `done`=1 from the next cycle. Entries already in the buffer still drain normally.
- `fetch_err` stays set until reset, even if a later redirect is in range.

## Test plan
- Reset, then `start` at cycle 2 with `out_ready`=1 and IMEM[i]=0x1000_0000+i: `out_valid` rises in cycle 4. `out_pc` steps 0,1,2,… each cycle and `out_instr` matches IMEM.
- Backpressure: drop `out_ready` for 5 cycles mid-stream. Count saturates at 2, `imem_addr` is frozen, no word is lost or duplicated, and the sequence resumes in order.
- Redirect to 0x20 while the buffer holds PCs 5 and 6, with a pop in the same cycle: PC 5 is delivered, PC 6 is dropped, `out_valid`=0 for one cycle, then `out_pc`=0x20.
- Run to the end with DEPTH=64: the last `out_pc`=63, `done`=1, `imem_addr`=64 and held. A subsequent redirect to 0 resumes RUN and clears `done`.
- Redirect to 0x50 (>=64): state DONE, `fetch_err`=1, and no `out_valid`. A redirect to 4 resumes fetching while `fetch_err` stays 1.
- Assert `reset` while the buffer is full in RUN: all outputs return to their reset values asynchronously, and nothing is fetched until the next `start`.
